hazard_ctrl: RTL and testbench

Pipeline hazard controller for the five-stage RISC-V core. It tracks destination-register state for the Execute, Memory and Writeback stages and generates the 2-bit forwarding selects that drive the Execute-stage operand `mux3` instances. It also generates fetch/decode stall and decode/execute flush controls for load-use hazards and taken branches. It owns its own shadow pipeline of hazard state, so the datapath only supplies Decode-stage fields and the branch decision.

---
 rtl/hazard_ctrl.sv | 108 ++++++++++
 tb/tb_hazard_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard controller for the five-stage core: shadow E/M/W destination state,
// load-use stall/flush, branch flush and Execute-stage forwarding selects.
// Forwarding is built only when HAZARD_FWD_EN is defined; otherwise stalls cover every RAW hazard.
module hazard_ctrl #(
  parameter int REGW = 5,
  parameter int CNTW = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [REGW-1:0] Rs1D,
  input  logic [REGW-1:0] Rs2D,
  input  logic [REGW-1:0] RdD,
  input  logic            RegWriteD,
  input  logic            LoadD,
  input  logic            PCSrcE,
  output logic            StallF,
  output logic            StallD,
  output logic            FlushD,
  output logic            FlushE,
  output logic [1:0]      ForwardAE,
  output logic [1:0]      ForwardBE,
  output logic [CNTW-1:0] StallCnt
);

  typedef struct packed {
    logic [REGW-1:0] rs1;
    logic [REGW-1:0] rs2;
    logic [REGW-1:0] rd;
    logic            reg_write;
    logic            load;
  } ex_t;

  typedef struct packed {
    logic [REGW-1:0] rd;
    logic            reg_write;
    logic            load;
  } dst_t;

  ex_t             e_q, e_d;
  dst_t            m_q, w_q;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            stall;

  // A producer only matters if it writes a non-x0 register one of the sources reads.
  function automatic logic hits(input logic rw, input logic [REGW-1:0] rd,
                                input logic [REGW-1:0] a, input logic [REGW-1:0] b);
    return rw && (rd != '0) && ((rd == a) || (rd == b));
  endfunction

`ifdef HAZARD_FWD_EN
  assign stall = e_q.load & hits(e_q.reg_write, e_q.rd, Rs1D, Rs2D);
`else
  assign stall = hits(e_q.reg_write, e_q.rd, Rs1D, Rs2D) |
                 hits(m_q.reg_write, m_q.rd, Rs1D, Rs2D);
`endif

  // Fields kept for completeness of the shadow stages but not consumed in every build.
  logic unused_bits;
  assign unused_bits = ^{e_q.rs1, e_q.rs2, e_q.load, m_q.load, w_q};

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    StallF    = stall;
    StallD    = stall;
    FlushD    = PCSrcE;
    FlushE    = stall | PCSrcE;
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
`ifdef HAZARD_FWD_EN
    if (hits(m_q.reg_write, m_q.rd, e_q.rs1, e_q.rs1))      ForwardAE = 2'b10;
    else if (hits(w_q.reg_write, w_q.rd, e_q.rs1, e_q.rs1)) ForwardAE = 2'b01;
    if (hits(m_q.reg_write, m_q.rd, e_q.rs2, e_q.rs2))      ForwardBE = 2'b10;
    else if (hits(w_q.reg_write, w_q.rd, e_q.rs2, e_q.rs2)) ForwardBE = 2'b01;
`endif
    if (reset) begin
      StallF    = 1'b0;
      StallD    = 1'b0;
      FlushD    = 1'b0;
      FlushE    = 1'b1;
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
    end
  end

  always_comb begin
    e_d = FlushE ? '0 : '{rs1: Rs1D, rs2: Rs2D, rd: RdD, reg_write: RegWriteD, load: LoadD};
    cnt_d = cnt_q;
    if (StallF && (cnt_q != '1)) cnt_d = cnt_q + CNTW'(1);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    if (reset) begin
      e_q   <= '0;
      m_q   <= '0;
      w_q   <= '0;
      cnt_q <= '0;
    end else begin
      e_q   <= e_d;
      m_q   <= '{rd: e_q.rd, reg_write: e_q.reg_write, load: e_q.load};
      w_q   <= m_q;
      cnt_q <= cnt_d;
    end
  end

  assign StallCnt = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus random traffic
// compared against an instruction-level pipeline model (follows HAZARD_FWD_EN).
module tb_hazard_ctrl;
  localparam int REGW = 5;
  localparam int CNTW = 4;
  localparam int CMAX = 15;

  logic            clk = 1'b0;
  logic            reset;
  logic [REGW-1:0] Rs1D, Rs2D, RdD;
  logic            RegWriteD, LoadD, PCSrcE;
  logic            StallF, StallD, FlushD, FlushE;
  logic [1:0]      ForwardAE, ForwardBE;
  logic [CNTW-1:0] StallCnt;

  hazard_ctrl #(.REGW(REGW), .CNTW(CNTW)) dut (
    .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .RegWriteD(RegWriteD), .LoadD(LoadD), .PCSrcE(PCSrcE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .StallCnt(StallCnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [REGW-1:0] rs1, rs2, rd;
    logic            rw, ld;
  } ins_t;

  int   checks = 0;
  int   failures = 0;
  ins_t in_e, in_m, in_w;   // instructions occupying E, M, W in the model
  int   cnt_m;
  bit   last_stall;

  function automatic ins_t mk(int rs1, int rs2, int rd, bit rw, bit ld);
    return '{rs1: REGW'(rs1), rs2: REGW'(rs2), rd: REGW'(rd), rw: rw, ld: ld};
  endfunction

  function automatic bit produces(ins_t p, logic [REGW-1:0] a, logic [REGW-1:0] b);
    return p.rw && p.rd != 0 && (p.rd == a || p.rd == b);
  endfunction

  function automatic bit exp_stall(ins_t d);
`ifdef HAZARD_FWD_EN
    return in_e.ld && produces(in_e, d.rs1, d.rs2);
`else
    return produces(in_e, d.rs1, d.rs2) || produces(in_m, d.rs1, d.rs2);
`endif
  endfunction

  function automatic logic [1:0] exp_fwd(logic [REGW-1:0] src);
`ifdef HAZARD_FWD_EN
    if (produces(in_m, src, src)) return 2'b10;
    if (produces(in_w, src, src)) return 2'b01;
`endif
    return 2'b00;
  endfunction

  // One clock: present Decode fields, compare all outputs with the model, advance.
  task automatic step(input ins_t d, input logic pc, input logic rst);
    logic st, fd, fe;
    logic [1:0] fa, fb;
    Rs1D = d.rs1; Rs2D = d.rs2; RdD = d.rd; RegWriteD = d.rw; LoadD = d.ld;
    PCSrcE = pc; reset = rst;
    #2;
    if (rst) begin
      st = 0; fd = 0; fe = 1; fa = 2'b00; fb = 2'b00;
    end else begin
      st = exp_stall(d); fd = pc; fe = st | pc;
      fa = exp_fwd(in_e.rs1); fb = exp_fwd(in_e.rs2);
    end
    checks += 7;
    if (StallF !== st) begin failures++; $display("FAIL StallF got=%b exp=%b t=%0t", StallF, st, $time); end
    if (StallD !== st) begin failures++; $display("FAIL StallD got=%b exp=%b t=%0t", StallD, st, $time); end
    if (FlushD !== fd) begin failures++; $display("FAIL FlushD got=%b exp=%b t=%0t", FlushD, fd, $time); end
    if (FlushE !== fe) begin failures++; $display("FAIL FlushE got=%b exp=%b t=%0t", FlushE, fe, $time); end
    if (ForwardAE !== fa) begin failures++; $display("FAIL ForwardAE got=%b exp=%b t=%0t", ForwardAE, fa, $time); end
    if (ForwardBE !== fb) begin failures++; $display("FAIL ForwardBE got=%b exp=%b t=%0t", ForwardBE, fb, $time); end
    if (StallCnt !== CNTW'(cnt_m)) begin failures++; $display("FAIL StallCnt got=%0d exp=%0d t=%0t", StallCnt, cnt_m, $time); end
    last_stall = st;
    @(posedge clk);
    if (rst) begin
      in_e = '0; in_m = '0; in_w = '0; cnt_m = 0;
    end else begin
      if (st && cnt_m < CMAX) cnt_m++;
      in_w = in_m; in_m = in_e;
      in_e = fe ? '0 : d;
    end
    @(negedge clk);
  endtask

  // Issue one instruction, holding it in Decode while the stall lasts.
  task automatic issue(input ins_t d, output int stalls);
    stalls = 0;
    for (int i = 0; i < 5; i++) begin
      step(d, 1'b0, 1'b0);
      if (!last_stall) return;
      stalls++;
    end
    checks++; failures++;
    $display("FAIL issue_timeout stalls=%0d limit=4", stalls);
  endtask

  task automatic peek_fwd(input string name, input logic [1:0] ea, input logic [1:0] eb);
    Rs1D = 0; Rs2D = 0; RdD = 0; RegWriteD = 0; LoadD = 0; PCSrcE = 0; reset = 0;
    #1;
    checks += 2;
    if (ForwardAE !== ea) begin failures++; $display("FAIL %s ForwardAE got=%b exp=%b", name, ForwardAE, ea); end
    if (ForwardBE !== eb) begin failures++; $display("FAIL %s ForwardBE got=%b exp=%b", name, ForwardBE, eb); end
  endtask

  task automatic check_stalls(input string name, input int got, input int exp, input logic [CNTW-1:0] c0);
    checks += 2;
    if (got != exp) begin failures++; $display("FAIL %s stall_cycles got=%0d exp=%0d", name, got, exp); end
    if (StallCnt - c0 !== CNTW'(exp)) begin failures++; $display("FAIL %s StallCnt_delta got=%0d exp=%0d", name, StallCnt - c0, exp); end
  endtask

  task automatic test_reset();
    step(mk(1, 2, 3, 1, 1), 1'b1, 1'b1);
    step(mk(0, 0, 0, 0, 0), 1'b0, 1'b0);
    checks++;
    if (StallCnt !== '0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", StallCnt); end
  endtask

  task automatic test_back_to_back();
    int s;
    logic [CNTW-1:0] c0;
    c0 = StallCnt;
    issue(mk(1, 2, 5, 1, 0), s);
    issue(mk(5, 3, 6, 1, 0), s);
`ifdef HAZARD_FWD_EN
    check_stalls("b2b", s, 0, c0);
    peek_fwd("b2b", 2'b10, 2'b00);
`else
    check_stalls("b2b", s, 2, c0);
    peek_fwd("b2b", 2'b00, 2'b00);
`endif
  endtask

  task automatic test_load_use();
    int s;
    logic [CNTW-1:0] c0;
    c0 = StallCnt;
    issue(mk(0, 0, 7, 1, 1), s);
    issue(mk(7, 7, 8, 1, 0), s);
`ifdef HAZARD_FWD_EN
    check_stalls("load_use", s, 1, c0);
    peek_fwd("load_use", 2'b01, 2'b01);
`else
    check_stalls("load_use", s, 2, c0);
    peek_fwd("load_use", 2'b00, 2'b00);
`endif
  endtask

  task automatic test_x0();
    int s;
    logic [CNTW-1:0] c0;
    c0 = StallCnt;
    issue(mk(1, 2, 0, 1, 0), s);
    issue(mk(0, 0, 3, 1, 0), s);
    check_stalls("x0", s, 0, c0);
    peek_fwd("x0", 2'b00, 2'b00);
  endtask

  task automatic test_branch_in_stall();
    int s;
    issue(mk(0, 0, 0, 0, 0), s);
    issue(mk(0, 0, 7, 1, 1), s);
    Rs1D = 7; Rs2D = 7; RdD = 8; RegWriteD = 1; LoadD = 0; PCSrcE = 1; reset = 0;
    #1;
    checks += 3;
    if (FlushD !== 1'b1) begin failures++; $display("FAIL br_stall FlushD got=%b exp=1", FlushD); end
    if (FlushE !== 1'b1) begin failures++; $display("FAIL br_stall FlushE got=%b exp=1", FlushE); end
    if (StallF !== 1'b1) begin failures++; $display("FAIL br_stall StallF got=%b exp=1", StallF); end
    step(mk(7, 7, 8, 1, 0), 1'b1, 1'b0);
    // The flushed slot must not supply a forward once it reaches M.
    issue(mk(0, 0, 0, 0, 0), s);
    issue(mk(8, 8, 9, 1, 0), s);
    peek_fwd("br_stall", 2'b00, 2'b00);
  endtask

  task automatic test_reset_mid_stall();
    int s;
    issue(mk(0, 0, 7, 1, 1), s);
    Rs1D = 7; Rs2D = 0; RdD = 8; RegWriteD = 1; LoadD = 0; PCSrcE = 0; reset = 1;
    #1;
    checks += 3;
    if (StallF !== 1'b0) begin failures++; $display("FAIL rst_stall StallF got=%b exp=0", StallF); end
    if (FlushE !== 1'b1) begin failures++; $display("FAIL rst_stall FlushE got=%b exp=1", FlushE); end
    if (ForwardAE !== 2'b00 || ForwardBE !== 2'b00) begin
      failures++; $display("FAIL rst_stall Forward got=%b/%b exp=00/00", ForwardAE, ForwardBE);
    end
    step(mk(7, 0, 8, 1, 0), 1'b0, 1'b1);
    checks++;
    if (StallCnt !== '0) begin failures++; $display("FAIL rst_stall StallCnt got=%0d exp=0", StallCnt); end
    issue(mk(7, 0, 8, 1, 0), s);
    peek_fwd("rst_stall", 2'b00, 2'b00);
  endtask

  task automatic test_random();
    ins_t d;
    for (int i = 0; i < 400; i++) begin
      d = mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
      step(d, $urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0);
    end
  endtask

  task automatic test_saturation();
    step(mk(0, 0, 0, 0, 0), 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      step(mk(0, 0, 7, 1, 1), 1'b0, 1'b0);
      step(mk(7, 7, 8, 1, 0), 1'b0, 1'b0);
    end
    checks++;
    if (StallCnt !== 4'hF) begin failures++; $display("FAIL saturation StallCnt got=%0d exp=15", StallCnt); end
  endtask

  initial begin
    Rs1D = 0; Rs2D = 0; RdD = 0; RegWriteD = 0; LoadD = 0; PCSrcE = 0; reset = 1;
    in_e = '0; in_m = '0; in_w = '0; cnt_m = 0; last_stall = 0;
    @(posedge clk);
    @(negedge clk);
    test_reset();
    test_back_to_back();
    test_load_use();
    test_x0();
    test_branch_in_stall();
    test_reset_mid_stall();
    test_random();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
